// File: rtl/gigatron_dpram.sv
// gigatron_dpram -- parametrised simple-dual-port synchronous RAM.
//
// One read port and one write port. Writes have byte-lane enables. Reads go
// through a 1- or 2-cycle pipeline and are flagged by o_rvalid. Reads are
// write-first, and same-address forwarding is resolved per byte lane. After
// reset, an optional sequencer fills every word with CLEAR_VALUE.
//
// Optional feature macro: GIGATRON_DPRAM_PARITY_EN
//   When defined, one even-parity bit is stored per byte lane. The macro also
//   adds the i_perr_inject input and the o_perr output.
//
// Ports:
//   i_clock        clock, all logic on the rising edge
//   i_reset        synchronous active-high reset
//   i_raddr/i_re   read address / read request
//   i_waddr/i_we   write address / write enable
//   i_wbe          byte-lane write enables (lane k = bits [8k+7:8k])
//   i_wdata        write data
//   o_rdata        read data (holds between reads)
//   o_rvalid       o_rdata valid this cycle
//   o_busy         clear sequence running; requests are ignored
//   i_perr_inject  (parity build) invert stored parity of written lanes
//   o_perr         (parity build) parity mismatch on the returned word
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_CLEAR | writing CLEAR_VALUE to mem[clr_cnt], one word per cycle
// ST_RUN   | normal operation, read/write requests accepted

module gigatron_dpram #(
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    READ_LATENCY   = 1,
  parameter int                    CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
`ifdef GIGATRON_DPRAM_PARITY_EN
  input  logic                    i_perr_inject,
  output logic                    o_perr,
`endif
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid,
  output logic                    o_busy
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    clr_en;
  logic                    wr_en;
  logic                    rd_en;

  // Stage-1 registers: raw array output plus what is needed to forward a
  // same-cycle write into the returned word.
  logic [DATA_WIDTH-1:0]   arr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [NBYTES-1:0]       wbe_q;
  logic                    hit_q;
  logic                    v1;
  logic [DATA_WIDTH-1:0]   merged;

  assign o_busy = (state == ST_CLEAR);
  assign clr_en = (state == ST_CLEAR) && !i_reset;
  assign wr_en  = (state == ST_RUN) && !i_reset && i_we;
  assign rd_en  = (state == ST_RUN) && i_re;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      if (CLEAR_ON_RESET != 0) state <= ST_CLEAR;
      else                     state <= ST_RUN;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) state <= ST_RUN;
    end
  end

  // Memory contents are never touched by reset itself.
  always_ff @(posedge i_clock) begin
    if (clr_en) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (wr_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_wbe[k]) mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  // Stage-1 registers only load on a read, so o_rdata holds while idle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      arr_q   <= '0;
      wdata_q <= '0;
      wbe_q   <= '0;
      hit_q   <= 1'b0;
      v1      <= 1'b0;
    end else begin
      v1 <= rd_en;
      if (rd_en) begin
        arr_q   <= mem[i_raddr];
        wdata_q <= i_wdata;
        wbe_q   <= i_wbe;
        hit_q   <= wr_en && (i_raddr == i_waddr);
      end
    end
  end

  always_comb begin
    merged = arr_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (hit_q && wbe_q[k]) merged[8*k +: 8] = wdata_q[8*k +: 8];
    end
  end

`ifdef GIGATRON_DPRAM_PARITY_EN
  logic [NBYTES-1:0] par_mem [DEPTH];
  logic [NBYTES-1:0] wpar;
  logic [NBYTES-1:0] clr_par;
  logic [NBYTES-1:0] par_arr_q;
  logic [NBYTES-1:0] wpar_q;
  logic [NBYTES-1:0] merged_par;
  logic [NBYTES-1:0] calc_par;
  logic              perr1;

  always_comb begin
    wpar       = '0;
    clr_par    = '0;
    merged_par = par_arr_q;
    calc_par   = '0;
    for (int k = 0; k < NBYTES; k++) begin
      wpar[k]    = (^i_wdata[8*k +: 8]) ^ i_perr_inject;
      clr_par[k] = ^CLEAR_VALUE[8*k +: 8];
      if (hit_q && wbe_q[k]) merged_par[k] = wpar_q[k];
      calc_par[k] = ^merged[8*k +: 8];
    end
  end

  always_ff @(posedge i_clock) begin
    if (clr_en) begin
      par_mem[clr_cnt] <= clr_par;
    end else if (wr_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (i_wbe[k]) par_mem[i_waddr][k] <= wpar[k];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      par_arr_q <= '0;
      wpar_q    <= '0;
    end else if (rd_en) begin
      par_arr_q <= par_mem[i_raddr];
      wpar_q    <= wpar;
    end
  end

  assign perr1 = v1 && (|(calc_par ^ merged_par));
`endif

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] rdata2;
      logic                  rvalid2;

      always_ff @(posedge i_clock) begin
        if (i_reset) begin
          rdata2  <= '0;
          rvalid2 <= 1'b0;
        end else begin
          rvalid2 <= v1;
          if (v1) rdata2 <= merged;
        end
      end

      assign o_rdata  = rdata2;
      assign o_rvalid = rvalid2;

`ifdef GIGATRON_DPRAM_PARITY_EN
      logic perr2;
      always_ff @(posedge i_clock) begin
        if (i_reset) perr2 <= 1'b0;
        else         perr2 <= perr1;
      end
      assign o_perr = perr2;
`endif
    end else begin : g_lat1
      assign o_rdata  = merged;
      assign o_rvalid = v1;
`ifdef GIGATRON_DPRAM_PARITY_EN
      assign o_perr   = perr1;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_gigatron_dpram.sv
// Self-checking bench for gigatron_dpram.
// Two instances share all inputs: u_lat1 (READ_LATENCY=1) and
// u_lat2 (READ_LATENCY=2). Both use a 16-bit word, 16 words and
// CLEAR_VALUE=16'hA5A5.
module tb_gigatron_dpram;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [3:0]  i_raddr, i_waddr;
  logic        i_re, i_we;
  logic [1:0]  i_wbe;
  logic [15:0] i_wdata;
  logic [15:0] rdata1, rdata2;
  logic        rvalid1, rvalid2, busy1, busy2;
`ifdef GIGATRON_DPRAM_PARITY_EN
  logic        i_perr_inject;
  logic        perr1, perr2;
`endif

  int passed = 0;
  int total  = 0;

  always #5 i_clock = ~i_clock;

  gigatron_dpram #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1),
                   .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) u_lat1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_raddr(i_raddr), .i_re(i_re),
    .i_waddr(i_waddr), .i_we(i_we), .i_wbe(i_wbe), .i_wdata(i_wdata),
`ifdef GIGATRON_DPRAM_PARITY_EN
    .i_perr_inject(i_perr_inject), .o_perr(perr1),
`endif
    .o_rdata(rdata1), .o_rvalid(rvalid1), .o_busy(busy1));

  gigatron_dpram #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2),
                   .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'hA5A5)) u_lat2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_raddr(i_raddr), .i_re(i_re),
    .i_waddr(i_waddr), .i_we(i_we), .i_wbe(i_wbe), .i_wdata(i_wdata),
`ifdef GIGATRON_DPRAM_PARITY_EN
    .i_perr_inject(i_perr_inject), .o_perr(perr2),
`endif
    .o_rdata(rdata2), .o_rvalid(rvalid2), .o_busy(busy2));

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic idle();
    i_re = 1'b0; i_we = 1'b0; i_wbe = 2'b00;
`ifdef GIGATRON_DPRAM_PARITY_EN
    i_perr_inject = 1'b0;
`endif
  endtask

  // Counts cycles from reset release until o_busy drops (bounded at 40).
  // With inject set, a write to addr 0 and a read are issued at the 15th
  // busy cycle, after addr 0 has already been cleared.
  task automatic measure_clear(input bit inject, output int n, output bit saw_rv);
    n = 0;
    saw_rv = 1'b0;
    while (busy1 && n < 40) begin
      if (inject && n == 14) begin
        i_we = 1'b1; i_waddr = 4'd0; i_wdata = 16'h5555; i_wbe = 2'b11;
        i_re = 1'b1; i_raddr = 4'd0;
      end else begin
        idle();
      end
      tick();
      n++;
      if (rvalid1 || rvalid2) saw_rv = 1'b1;
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    i_raddr = '0; i_waddr = '0; i_wdata = '0;
    i_reset = 1'b1;
    tick();
    tick();
    total++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) $display("FAIL reset_busy: got %b/%b expected 1/1", busy1, busy2);
    else passed++;
    total++;
    if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) $display("FAIL reset_rvalid: got %b/%b expected 0/0", rvalid1, rvalid2);
    else passed++;
    total++;
    if (rdata1 !== 16'h0 || rdata2 !== 16'h0) $display("FAIL reset_rdata: got %h/%h expected 0000/0000", rdata1, rdata2);
    else passed++;
  endtask

  task automatic test_clear();
    int n;
    bit saw;
    i_reset = 1'b0;
    measure_clear(1'b0, n, saw);
    total++;
    if (n !== 16) $display("FAIL clear_busy_cycles: got %0d expected 16", n);
    else passed++;
    total++;
    if (saw !== 1'b0) $display("FAIL clear_no_rvalid: got %b expected 0", saw);
    else passed++;
    total++;
    if (busy2 !== 1'b0) $display("FAIL clear_busy2_done: got %b expected 0", busy2);
    else passed++;
    for (int a = 0; a < 16; a++) begin
      i_re = 1'b1; i_raddr = 4'(a);
      tick();
      total++;
      if (rvalid1 !== 1'b1 || rdata1 !== 16'hA5A5)
        $display("FAIL clear_read[%0d]: got v=%b d=%h expected v=1 d=a5a5", a, rvalid1, rdata1);
      else passed++;
    end
    idle();
    tick();
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 16'hA5A5)
      $display("FAIL clear_read_lat2_last: got v=%b d=%h expected v=1 d=a5a5", rvalid2, rdata2);
    else passed++;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit saw;
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    repeat (7) tick();
    total++;
    if (busy1 !== 1'b1) $display("FAIL midclear_busy_at7: got %b expected 1", busy1);
    else passed++;
    i_reset = 1'b1;
    tick();
    total++;
    if (busy1 !== 1'b1) $display("FAIL midclear_busy_in_reset: got %b expected 1", busy1);
    else passed++;
    i_reset = 1'b0;
    measure_clear(1'b1, n, saw);
    total++;
    if (n !== 16) $display("FAIL midclear_busy_cycles: got %0d expected 16", n);
    else passed++;
    total++;
    if (saw !== 1'b0) $display("FAIL midclear_no_rvalid: got %b expected 0", saw);
    else passed++;
    i_re = 1'b1; i_raddr = 4'd0;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'hA5A5)
      $display("FAIL midclear_write_ignored: got v=%b d=%h expected v=1 d=a5a5", rvalid1, rdata1);
    else passed++;
    tick();
  endtask

  task automatic test_byte_lanes();
    i_we = 1'b1; i_waddr = 4'd3; i_wdata = 16'h1234; i_wbe = 2'b11;
    tick();
    i_wdata = 16'hAB00; i_wbe = 2'b10;
    tick();
    idle();
    i_re = 1'b1; i_raddr = 4'd3;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'hAB34)
      $display("FAIL lanes_lat1: got v=%b d=%h expected v=1 d=ab34", rvalid1, rdata1);
    else passed++;
    tick();
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 16'hAB34)
      $display("FAIL lanes_lat2: got v=%b d=%h expected v=1 d=ab34", rvalid2, rdata2);
    else passed++;
  endtask

  task automatic test_collision();
    i_we = 1'b1; i_waddr = 4'd5; i_wdata = 16'h1111; i_wbe = 2'b11;
    tick();
    i_wdata = 16'h22FF; i_wbe = 2'b01;
    i_re = 1'b1; i_raddr = 4'd5;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h11FF)
      $display("FAIL collision_lat1: got v=%b d=%h expected v=1 d=11ff", rvalid1, rdata1);
    else passed++;
    tick();
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 16'h11FF)
      $display("FAIL collision_lat2: got v=%b d=%h expected v=1 d=11ff", rvalid2, rdata2);
    else passed++;
    i_re = 1'b1; i_raddr = 4'd5;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h11FF)
      $display("FAIL collision_reread: got v=%b d=%h expected v=1 d=11ff", rvalid1, rdata1);
    else passed++;
    tick();
  endtask

  task automatic test_latency();
    i_re = 1'b1; i_raddr = 4'd3;
    tick();
    i_raddr = 4'd5;
    tick();
    idle();
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 16'hAB34)
      $display("FAIL lat2_n2: got v=%b d=%h expected v=1 d=ab34", rvalid2, rdata2);
    else passed++;
    tick();
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 16'h11FF)
      $display("FAIL lat2_n3: got v=%b d=%h expected v=1 d=11ff", rvalid2, rdata2);
    else passed++;
    total++;
    if (rvalid1 !== 1'b0 || rdata1 !== 16'h11FF)
      $display("FAIL lat1_hold: got v=%b d=%h expected v=0 d=11ff", rvalid1, rdata1);
    else passed++;
    tick();
    total++;
    if (rvalid2 !== 1'b0 || rdata2 !== 16'h11FF)
      $display("FAIL lat2_n4_hold: got v=%b d=%h expected v=0 d=11ff", rvalid2, rdata2);
    else passed++;
  endtask

  // A read at N must not see a write to the same address at N+1.
  task automatic test_back_to_back();
    i_re = 1'b1; i_raddr = 4'd3;
    tick();
    i_raddr = 4'd7;
    i_we = 1'b1; i_waddr = 4'd3; i_wdata = 16'h0000; i_wbe = 2'b11;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'hA5A5)
      $display("FAIL b2b_lat1_second: got v=%b d=%h expected v=1 d=a5a5", rvalid1, rdata1);
    else passed++;
    total++;
    if (rvalid2 !== 1'b1 || rdata2 !== 16'hAB34)
      $display("FAIL b2b_lat2_first: got v=%b d=%h expected v=1 d=ab34", rvalid2, rdata2);
    else passed++;
    i_re = 1'b1; i_raddr = 4'd3;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || rdata1 !== 16'h0000)
      $display("FAIL b2b_write_landed: got v=%b d=%h expected v=1 d=0000", rvalid1, rdata1);
    else passed++;
    tick();
  endtask

`ifdef GIGATRON_DPRAM_PARITY_EN
  task automatic test_parity();
    i_we = 1'b1; i_waddr = 4'd9; i_wdata = 16'h000F; i_wbe = 2'b01; i_perr_inject = 1'b1;
    tick();
    idle();
    i_re = 1'b1; i_raddr = 4'd9;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || perr1 !== 1'b1)
      $display("FAIL parity_inject_lat1: got v=%b perr=%b expected v=1 perr=1", rvalid1, perr1);
    else passed++;
    tick();
    total++;
    if (rvalid2 !== 1'b1 || perr2 !== 1'b1)
      $display("FAIL parity_inject_lat2: got v=%b perr=%b expected v=1 perr=1", rvalid2, perr2);
    else passed++;
    i_we = 1'b1; i_waddr = 4'd9; i_wdata = 16'h000F; i_wbe = 2'b01;
    tick();
    idle();
    i_re = 1'b1; i_raddr = 4'd9;
    tick();
    idle();
    total++;
    if (rvalid1 !== 1'b1 || perr1 !== 1'b0)
      $display("FAIL parity_clean: got v=%b perr=%b expected v=1 perr=0", rvalid1, perr1);
    else passed++;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_clear();
    test_reset_mid_clear();
    test_byte_lanes();
    test_collision();
    test_latency();
    test_back_to_back();
`ifdef GIGATRON_DPRAM_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/gigatron_dpram.md
Name: gigatron_dpram

Overview:
Parametrised simple-dual-port synchronous RAM, successor to the 8-bit Gigatron RAM. It adds configurable data/address width and byte-lane write enables. It also adds a 1- or 2-cycle read pipeline with a valid flag, write-first forwarding that is correct per byte lane, and a post-reset clear sequencer. It sits between the CPU/video fetch logic and block RAM, and serves as the main memory for wider-bus variants.

Parameters:
DATA_WIDTH, 8, data word width in bits; must be a multiple of 8; NBYTES = DATA_WIDTH/8
ADDR_WIDTH, 16, address width; DEPTH = 2**ADDR_WIDTH words
READ_LATENCY, 1, cycles from i_re to o_rvalid; legal values 1 or 2
CLEAR_ON_RESET, 1, 1 = write CLEAR_VALUE to every word after reset
CLEAR_VALUE, 0, DATA_WIDTH-bit fill word used by the clear sequencer

Ports:
i_clock  input  1  clock; all logic on rising edge
i_reset  input  1  synchronous reset, active-high
i_raddr  input  ADDR_WIDTH  read address
i_re  input  1  read request
i_waddr  input  ADDR_WIDTH  write address
i_we  input  1  write enable
i_wbe  input  NBYTES  byte-lane enables; lane k = bits [8k+7:8k]
i_wdata  input  DATA_WIDTH  write data
o_rdata  output  DATA_WIDTH  read data
o_rvalid  output  1  o_rdata valid this cycle
o_busy  output  1  clear sequence in progress; requests ignored

Behaviour:
- Reset: single clock; reset is synchronous, active-high (i_reset sampled on i_clock rising edge). While i_reset=1: o_rdata=0, o_rvalid=0, pipeline valid bits=0, clear counter=0. o_busy=1 if CLEAR_ON_RESET else 0. Memory contents are untouched by reset itself.
- FSM states CLEAR and RUN.
  - Reset enters CLEAR if CLEAR_ON_RESET, else RUN.
  - CLEAR: one word per cycle, mem[cnt] <= CLEAR_VALUE, cnt increments from 0. After writing DEPTH-1, go to RUN. First RUN cycle is exactly DEPTH cycles after reset release. o_busy=1 throughout CLEAR.
  - i_reset during CLEAR restarts at cnt=0.
- Requests in CLEAR: i_we and i_re ignored; no writes happen and no o_rvalid pulses.
- Write (RUN, i_we=1): for each lane k with i_wbe[k]=1, mem[i_waddr] lane k <= i_wdata lane k. Other lanes are unchanged. i_wbe=0 with i_we=1 is a no-op.
- Read (RUN, i_re=1 at cycle N): o_rvalid=1 and o_rdata = word at i_raddr in cycle N+READ_LATENCY.
  - The returned word reflects all writes through cycle N (write-first). Writes in later cycles do not affect it.
  - One read per cycle; back-to-back reads give back-to-back o_rvalid.
- Same-address collision (i_re & i_we & i_raddr==i_waddr, cycle N): returned lanes with i_wbe=1 come from i_wdata; other lanes hold the pre-write memory contents. Implementation: register wdata, wbe and a hit flag, then merge per lane with the array output.
- i_re=0 at N: o_rvalid=0 at N+READ_LATENCY; o_rdata holds its previous value.
- READ_LATENCY=2: second stage registers the merged data and valid. Forwarding is resolved only in stage 1.
- Addresses wrap naturally within ADDR_WIDTH; there are no out-of-range cases.

Optional Feature:
GIGATRON_DPRAM_PARITY_EN
- Defined:
  - One even-parity bit is stored per byte lane, written alongside the data and cleared consistently by CLEAR.
  - Extra input port i_perr_inject (1): when high during a write, the stored parity of the written lanes is inverted.
  - Extra output o_perr (1): asserted with o_rvalid when any returned lane's recomputed parity mismatches its stored parity; reset value 0.
  - Forwarded lanes use the forwarded parity.
- Undefined: neither port exists and no parity storage is built.

Test Plan:
- Clear: DATA_WIDTH=16, ADDR_WIDTH=4, CLEAR_VALUE=16'hA5A5. Pulse reset, then run 16 cycles -> o_busy=1 for exactly 16 cycles. Reading addresses 0..15 then returns 16'hA5A5 each, with o_rvalid 1 cycle later.
- Reset mid-clear: assert i_reset at cnt=7 -> o_busy stays 1, and the clear restarts so it finishes 16 cycles after release. A write issued while busy is ignored.
- Byte lanes: write 16'h1234 wbe=2'b11 to addr 3, then 16'hAB00 wbe=2'b10 -> read addr 3 returns 16'hAB34.
- Collision: mem[5]=16'h1111. In the same cycle, write 16'h22FF wbe=2'b01 to addr 5 and read addr 5 -> o_rdata=16'h11FF. A subsequent read also returns 16'h11FF.
- Latency: READ_LATENCY=2, reads on cycles N and N+1 and none on N+2 -> o_rvalid=1 at N+2 and N+3, 0 at N+4. o_rdata holds its value at N+4.
- Parity (macro on): write 8'h0F with i_perr_inject=1 to addr 9, read addr 9 -> o_perr=1 with o_rvalid. Rewrite without inject -> o_perr=0.
